// File: rtl/vga_timing_gen.sv
// Free-running VGA pixel timing: raster position, active-video flag, active-low syncs,
// a frame_start pulse on pixel (0,0) and an 8-bit frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // 11-bit thresholds so a visible width of exactly 1024 still compares correctly.
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [9:0] x_q, y_q;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q, fs_d;
  logic       first_q, first_d;
  logic [7:0] fc_q, fc_d;
  logic [10:0] hx, vy;

  always_comb begin
    hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
    end
  end

  // Flags are decoded from the next counter value so they register alongside DrawX/DrawY.
  always_comb begin
    hx      = {1'b0, hc_d};
    vy      = {1'b0, vc_d};
    blank_d = (hx < H_VIS) && (vy < V_VIS);
    hs_d    = !((hx >= HS_ON) && (hx < HS_OFF));
    vs_d    = !((vy >= VS_ON) && (vy < VS_OFF));
    fs_d    = (hc_d == 10'd0) && (vc_d == 10'd0);
    first_d = first_q;
    fc_d    = fc_q;
    if (fs_d) begin
      first_d = 1'b0;
      if (!first_q) fc_d = fc_q + 8'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= H_LAST;
      vc_q    <= V_LAST;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      first_q <= 1'b1;
      fc_q    <= 8'd0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      x_q     <= hc_d;
      y_q     <= vc_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      first_q <= first_d;
      fc_q    <= fc_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing plus two shortened timings, checked every
// cycle against an arithmetic raster model, with directed probes and random async resets.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: default 640x480; B: tiny 7x6 raster; C: narrow lines with default vertical timing.
  localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48, AVV = 480, AVF = 10, AVS = 2, AVB = 33;
  localparam int BHV = 4, BHF = 1, BHS = 1, BHB = 1, BVV = 3, BVF = 1, BVS = 1, BVB = 1;
  localparam int CHV = 4, CHF = 1, CHS = 1, CHB = 1, CVV = 480, CVF = 10, CVS = 2, CVB = 33;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic       a_bl, a_hs, a_vs, a_fs, b_bl, b_hs, b_vs, b_fs, c_bl, c_hs, c_vs, c_fs;
  logic [7:0] a_fc, b_fc, c_fc;

  vga_timing_gen dut_a (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
    .hs(a_hs), .vs(a_vs), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_VISIBLE(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
  ) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
    .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(CHV), .H_FP(CHF), .H_SYNC(CHS), .H_BP(CHB),
    .V_VISIBLE(CVV), .V_FP(CVF), .V_SYNC(CVS), .V_BP(CVB)
  ) dut_c (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(c_x), .DrawY(c_y), .blank(c_bl),
    .hs(c_hs), .vs(c_vs), .frame_start(c_fs), .frame_count(c_fc)
  );

  // Toy sprite mapper: a box over a background colour, black whenever blank is low.
  logic        in_sprite;
  logic [23:0] rgb;
  assign in_sprite = (a_x >= 10'd100) && (a_x < 10'd164) && (a_y >= 10'd50) && (a_y < 10'd114);
  assign rgb = !a_bl ? 24'h000000 : (in_sprite ? 24'hff8000 : 24'h102040);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       bl;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
  } px_t;

  // Raster model: the t-th edge after release shows pixel t mod (H_TOTAL*V_TOTAL).
  function automatic px_t model(input int hv, input int hf, input int hsw, input int hb,
                                input int vv, input int vf, input int vsw, input int vb,
                                input longint cyc, input logic rstn);
    px_t r;
    longint ht, vt, fl, t, p, x, y;
    r = '{x: 10'd0, y: 10'd0, bl: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, fc: 8'd0};
    if (rstn && cyc > 0) begin
      ht = longint'(hv) + longint'(hf) + longint'(hsw) + longint'(hb);
      vt = longint'(vv) + longint'(vf) + longint'(vsw) + longint'(vb);
      fl = ht * vt;
      t  = cyc - 1;
      p  = t % fl;
      x  = p % ht;
      y  = p / ht;
      r.x  = 10'(x);
      r.y  = 10'(y);
      r.bl = (x < longint'(hv)) && (y < longint'(vv));
      r.hs = !((x >= longint'(hv + hf)) && (x < longint'(hv + hf + hsw)));
      r.vs = !((y >= longint'(vv + vf)) && (y < longint'(vv + vf + vsw)));
      r.fs = (p == 0);
      r.fc = 8'((t / fl) % 256);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input px_t e, input logic [9:0] x, input logic [9:0] y,
                     input logic bl, input logic h, input logic v, input logic fs,
                     input logic [7:0] fc);
    chk({nm, ".DrawX"}, 32'(x), 32'(e.x));
    chk({nm, ".DrawY"}, 32'(y), 32'(e.y));
    chk({nm, ".blank"}, 32'(bl), 32'(e.bl));
    chk({nm, ".hs"}, 32'(h), 32'(e.hs));
    chk({nm, ".vs"}, 32'(v), 32'(e.vs));
    chk({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({nm, ".frame_count"}, 32'(fc), 32'(e.fc));
  endtask

  longint cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    px_t ea;
    ea = model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, cyc, reset_n);
    cmp("A", ea, a_x, a_y, a_bl, a_hs, a_vs, a_fs, a_fc);
    cmp("B", model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, cyc, reset_n),
        b_x, b_y, b_bl, b_hs, b_vs, b_fs, b_fc);
    cmp("C", model(CHV, CHF, CHS, CHB, CVV, CVF, CVS, CVB, cyc, reset_n),
        c_x, c_y, c_bl, c_hs, c_vs, c_fs, c_fc);
    if (reset_n && cyc > 0 && (ea.x >= 10'd640 || ea.y >= 10'd480))
      chk("mapper_rgb_black", rgb, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input int x, input int y, input int budget);
    int n = 0;
    do begin step(); n++; end while (!(32'(a_x) == x && 32'(a_y) == y) && n < budget);
    if (!(32'(a_x) == x && 32'(a_y) == y)) begin
      checks++; errors++;
      $display("FAIL wait_a timeout target=(%0d,%0d) actual=(%0d,%0d)", x, y, a_x, a_y);
    end
  endtask

  task automatic wait_c(input int x, input int y, input int budget);
    int n = 0;
    do begin step(); n++; end while (!(32'(c_x) == x && 32'(c_y) == y) && n < budget);
    if (!(32'(c_x) == x && 32'(c_y) == y)) begin
      checks++; errors++;
      $display("FAIL wait_c timeout target=(%0d,%0d) actual=(%0d,%0d)", x, y, c_x, c_y);
    end
  endtask

  task automatic wait_fs(input int which, input int budget, output int n);
    logic hit;
    n = 0;
    do begin
      step(); n++;
      hit = (which == 1) ? b_fs : c_fs;
    end while (!hit && n < budget);
    if (!hit) begin
      checks++; errors++;
      $display("FAIL wait_fs timeout inst=%0d cycles=%0d", which, n);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".DrawX"}, 32'(a_x), 32'd0);
    chk({tag, ".DrawY"}, 32'(a_y), 32'd0);
    chk({tag, ".blank"}, 32'(a_bl), 32'd0);
    chk({tag, ".hs"}, 32'(a_hs), 32'd1);
    chk({tag, ".vs"}, 32'(a_vs), 32'd1);
    chk({tag, ".frame_start"}, 32'(a_fs), 32'd0);
    chk({tag, ".frame_count"}, 32'(a_fc), 32'd0);
  endtask

  initial begin
    px_t m;
    int  n;

    // Pin the model against hand-computed values.
    m = model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 656, 1'b1);
    chk("model_hs_x655", 32'(m.hs), 32'd1);
    m = model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 657, 1'b1);
    chk("model_hs_x656", 32'(m.hs), 32'd0);
    m = model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 420001, 1'b1);
    chk("model_frame1_fs", 32'(m.fs), 32'd1);
    chk("model_frame1_fc", 32'(m.fc), 32'd1);
    m = model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 801, 1'b1);
    chk("model_line1_y", 32'(m.y), 32'd1);

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("in_reset");
    #1 reset_n = 1'b1;

    fork
      begin
        step();
        chk("a_first_x", 32'(a_x), 32'd0);
        chk("a_first_y", 32'(a_y), 32'd0);
        chk("a_first_blank", 32'(a_bl), 32'd1);
        chk("a_first_fs", 32'(a_fs), 32'd1);
        chk("a_first_fc", 32'(a_fc), 32'd0);
        step();
        chk("a_second_x", 32'(a_x), 32'd1);
        chk("a_second_fs", 32'(a_fs), 32'd0);
        wait_a(639, 0, 1000);
        chk("a_blank_x639", 32'(a_bl), 32'd1);
        step();
        chk("a_blank_x640", 32'(a_bl), 32'd0);
        wait_a(655, 0, 1000);
        chk("a_hs_x655", 32'(a_hs), 32'd1);
        step();
        chk("a_hs_x656", 32'(a_hs), 32'd0);
        wait_a(751, 0, 1000);
        chk("a_hs_x751", 32'(a_hs), 32'd0);
        step();
        chk("a_hs_x752", 32'(a_hs), 32'd1);
        wait_a(799, 0, 1000);
        step();
        chk("a_wrap_x", 32'(a_x), 32'd0);
        chk("a_wrap_y", 32'(a_y), 32'd1);
      end
      begin
        wait_fs(1, 100, n);
        chk("b_fc_first", 32'(b_fc), 32'd0);
        for (int i = 1; i <= 256; i++) begin
          wait_fs(1, 100, n);
          chk("b_period", n, 32'd42);
          if (i == 1)   chk("b_fc_second", 32'(b_fc), 32'd1);
          if (i == 255) chk("b_fc_255", 32'(b_fc), 32'd255);
        end
        chk("b_fc_wrap", 32'(b_fc), 32'd0);
      end
      begin
        wait_c(0, 479, 5000);
        chk("c_blank_y479", 32'(c_bl), 32'd1);
        wait_c(0, 480, 100);
        chk("c_blank_y480", 32'(c_bl), 32'd0);
        wait_c(0, 489, 100);
        chk("c_vs_y489", 32'(c_vs), 32'd1);
        wait_c(0, 490, 100);
        chk("c_vs_y490", 32'(c_vs), 32'd0);
        wait_c(0, 491, 100);
        chk("c_vs_y491", 32'(c_vs), 32'd0);
        wait_c(0, 492, 100);
        chk("c_vs_y492", 32'(c_vs), 32'd1);
        wait_c(6, 524, 1000);
        chk("c_fs_last", 32'(c_fs), 32'd0);
        step();
        chk("c_wrap_x", 32'(c_x), 32'd0);
        chk("c_wrap_y", 32'(c_y), 32'd0);
        chk("c_wrap_fs", 32'(c_fs), 32'd1);
        chk("c_wrap_fc", 32'(c_fc), 32'd1);
        wait_fs(2, 5000, n);
        chk("c_period", n, 32'd3675);
        chk("c_fc_third", 32'(c_fc), 32'd2);
      end
    join

    // Mid-frame asynchronous reset, asserted between clock edges.
    wait_a(300, 40, 40000);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_a("midframe_reset");
    chk("midframe_reset.c_x", 32'(c_x), 32'd0);
    chk("midframe_reset.b_fc", 32'(b_fc), 32'd0);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #2 reset_n = 1'b1;
    step();
    chk("restart_x", 32'(a_x), 32'd0);
    chk("restart_y", 32'(a_y), 32'd0);
    chk("restart_blank", 32'(a_bl), 32'd1);
    chk("restart_fs", 32'(a_fs), 32'd1);
    chk("restart_fc", 32'(a_fc), 32'd0);

    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(50, 3000)) @(posedge clk);
      #($urandom_range(1, 3));
      reset_n = 1'b0;
      #1;
      chk_reset_a("random_reset");
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #2 reset_n = 1'b1;
    end

    repeat (2000) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
